peak_tracker: RTL

Parametrised running-extremum tracker: accepts one sample of CHANNELS unsigned words per cycle and maintains the maximum or minimum non-ignored value seen since the last clear, along with the channel index that produced it. It replaces the fixed four-channel, max-only highest-value comparator in the user project area. It adds a registered reduction pipeline, selectable min/max mode, an explicit clear, a peak-changed pulse and a saturating sample counter.

---
 rtl/peak_tracker_if.sv | 29 ++
 rtl/peak_tracker.sv | 125 ++++++++++++
 2 files changed

// File: rtl/peak_tracker_if.sv
// Sample/result bundle for peak_tracker: one CHANNELS-wide sample in, running extremum out.
interface peak_tracker_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int COUNT_W  = 16
);
    localparam int IDX_W = $clog2(CHANNELS);

    logic                      in_valid;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic                      mode;
    logic                      clear;

    logic                      peak_valid;
    logic [WIDTH-1:0]          peak_value;
    logic [IDX_W-1:0]          peak_index;
    logic                      peak_update;
    logic [COUNT_W-1:0]        sample_count;

    modport master (
        output in_valid, in_data, mode, clear,
        input  peak_valid, peak_value, peak_index, peak_update, sample_count
    );

    modport slave (
        input  in_valid, in_data, mode, clear,
        output peak_valid, peak_value, peak_index, peak_update, sample_count
    );
endinterface

// File: rtl/peak_tracker.sv
// Running max/min tracker over CHANNELS unsigned words per sample, with a
// registered channel reduction (S1) and a state-update stage (S2).
module peak_tracker #(
    parameter int WIDTH       = 8,
    parameter int CHANNELS    = 4,
    parameter int IGNORE_ZERO = 1,
    parameter int COUNT_W     = 16
) (
    input logic           clk,
    input logic           reset_n,
    peak_tracker_if.slave bus
);
    localparam int IDX_W = $clog2(CHANNELS);

    typedef logic [WIDTH-1:0]   word_t;
    typedef logic [IDX_W-1:0]   idx_t;
    typedef logic [COUNT_W-1:0] count_t;

    function automatic logic qualifies(input word_t w);
        return (IGNORE_ZERO == 0) || (w != '0);
    endfunction

    // Strict comparison: equal values never win, which keeps the earliest/lowest.
    function automatic logic better(input word_t a, input word_t b, input logic min_mode);
        return min_mode ? (a < b) : (a > b);
    endfunction

    function automatic count_t sat_inc(input count_t c);
        return (&c) ? c : c + 1'b1;
    endfunction

    word_t red_value;
    idx_t  red_index;
    logic  red_ok;

    always_comb begin
        red_value = '0;
        red_index = '0;
        red_ok    = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (qualifies(bus.in_data[c*WIDTH +: WIDTH]) &&
                (!red_ok || better(bus.in_data[c*WIDTH +: WIDTH], red_value, bus.mode))) begin
                red_value = bus.in_data[c*WIDTH +: WIDTH];
                red_index = idx_t'(c);
                red_ok    = 1'b1;
            end
        end
    end

    // ---- S1: reduced candidate ----
    logic  vld_p1;
    word_t value_p1;
    idx_t  index_p1;
    logic  ok_p1;
    logic  mode_p1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= bus.in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.in_valid) begin
            value_p1 <= red_value;
            index_p1 <= red_index;
            ok_p1    <= red_ok;
            mode_p1  <= bus.mode;
        end
    end

    // ---- S2: tracked extremum ----
    logic   mode_p2;
    logic   peak_valid_p2;
    word_t  peak_value_p2;
    idx_t   peak_index_p2;
    logic   peak_update_p2;
    count_t count_p2;

    logic   restart;
    logic   take;
    count_t count_base;

    // A mode change behaves as a clear immediately ahead of the sample.
    assign restart    = bus.clear || (vld_p1 && (mode_p1 != mode_p2));
    assign count_base = restart ? '0 : count_p2;
    assign take       = vld_p1 && ok_p1 &&
                        (restart || !peak_valid_p2 || better(value_p1, peak_value_p2, mode_p1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_p2        <= 1'b0;
            peak_valid_p2  <= 1'b0;
            peak_value_p2  <= '0;
            peak_index_p2  <= '0;
            peak_update_p2 <= 1'b0;
            count_p2       <= '0;
        end else begin
            peak_update_p2 <= take;
            if (vld_p1) begin
                mode_p2  <= mode_p1;
                count_p2 <= sat_inc(count_base);
            end else if (restart) begin
                count_p2 <= '0;
            end
            if (take) begin
                peak_valid_p2 <= 1'b1;
                peak_value_p2 <= value_p1;
                peak_index_p2 <= index_p1;
            end else if (restart) begin
                peak_valid_p2 <= 1'b0;
                peak_value_p2 <= '0;
                peak_index_p2 <= '0;
            end
        end
    end

    assign bus.peak_valid   = peak_valid_p2;
    assign bus.peak_value   = peak_value_p2;
    assign bus.peak_index   = peak_index_p2;
    assign bus.peak_update  = peak_update_p2;
    assign bus.sample_count = count_p2;
endmodule
